spart_io_sched: RTL and testbench
=================================

Name: spart_io_sched

Overview:
Owns the SPART processor-side bus (iocs/iorw/ioaddr/databus) and sequences every access to it. After reset it programs the baud divisor. It then arbitrates between receive reads (on rda) and transmit writes drained from a small internal TX byte FIFO (gated by tbr). Upstream word packers/unpackers use simple valid/ready byte streams and never touch the SPART bus directly.

Parameters:
BAUD_DIV, 16'd325, divisor written to SPART DB registers (9600 baud at 50 MHz)
TX_DEPTH, 4, TX FIFO entries; power of 2, minimum 2
HOLD_CYC, 2, cycles after a RD/WR during which rda/tbr are ignored (status settle time)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
cfg_req  in  1  pulse: re-program baud divisor (honoured in IDLE only)
rda  in  1  SPART receive-data-available
tbr  in  1  SPART transmit-buffer-ready
iocs  out  1  SPART chip select
iorw  out  1  1=read, 0=write
ioaddr  out  2  00 data, 01 status, 10 DB low, 11 DB high
db_out  out  8  write data toward SPART databus
db_oe  out  1  drive enable for db_out (top-level tristate)
db_in  in  8  databus read value
tx_byte  in  8  byte to transmit
tx_valid  in  1  tx_byte valid
tx_ready  out  1  FIFO not full
rx_byte  out  8  received byte
rx_valid  out  1  one-cycle pulse, rx_byte valid
cfg_done  out  1  divisor programmed, bus live
rda_stuck_cnt  out  8  saturating count of rda still high after hold

Behaviour:
- Reset, async active-low: state=CFG_LO; FIFO empty; rx_byte=0; rx_valid=0; cfg_done=0; rda_stuck_cnt=0; hold counter=0.
- Bus outputs are a Moore decode of the registered state.
  - CFG_LO: iocs=1, iorw=0, ioaddr=10, db_out=BAUD_DIV[7:0], db_oe=1.
  - CFG_HI: same, but ioaddr=11 and db_out=BAUD_DIV[15:8].
  - RD: iocs=1, iorw=1, ioaddr=00, db_oe=0.
  - WR: iocs=1, iorw=0, ioaddr=00, db_out=FIFO head, db_oe=1.
  - IDLE/HOLD: iocs=0, iorw=1, ioaddr=01, db_oe=0, db_out=0.
- Transitions:
  - CFG_LO->CFG_HI->IDLE, one cycle each. cfg_done is set on leaving CFG_HI.
  - IDLE priority: cfg_req (->CFG_LO, cfg_done cleared) > rda (->RD) > (tbr && FIFO non-empty) (->WR) > stay.
  - RD->HOLD: db_in is captured into rx_byte at the RD edge; rx_valid=1 for exactly the following cycle.
  - WR->HOLD: FIFO pops at the WR edge.
  - HOLD lasts HOLD_CYC cycles, then ->IDLE.
- rda_stuck_cnt increments (saturating at 255) when rda=1 in the last HOLD cycle following an RD.
- cfg_req outside IDLE is dropped. FIFO contents survive re-config.
- Before cfg_done=1, rda and tbr are ignored, but tx pushes are still accepted up to full.
- FIFO:
  - tx_ready = !full; push on tx_valid && tx_ready.
  - Pointers are log2(TX_DEPTH) bits and wrap; count is log2(TX_DEPTH)+1 bits.
  - Push and pop in the same cycle leaves the count unchanged.
  - Full: tx_ready=0, tx_valid ignored.
  - Empty: WR is never entered.
- Latency, byte into an empty FIFO with IDLE, tbr=1, rda=0: pushed at edge N, WR state during cycle N+1..N+2 (db_out valid in cycle after head becomes visible), i.e. WR asserted 2 cycles after the push edge.
- RD latency: rda sampled in IDLE at edge N → RD during cycle N+1 → rx_valid during cycle N+2.
- rx has no backpressure; consumers must accept every rx_valid pulse.
- Async reset mid-access drops iocs the instant rst falls and restarts the configuration sequence.

Decomposition:
- Package spart_pkg:
  - state enum {CFG_LO, CFG_HI, IDLE, RD, WR, HOLD};
  - ioaddr constants ADDR_DATA=2'b00, ADDR_STAT=2'b01, ADDR_DBL=2'b10, ADDR_DBH=2'b11;
  - default BAUD_DIV.
- Sub-module spart_tx_fifo(TX_DEPTH): sync byte FIFO with async active-low reset, push/pop/full/empty/head.

Test Plan:
- Reset release, rda=0, tbr=1 → cycle 1 ioaddr=10, db_out=0x45; cycle 2 ioaddr=11, db_out=0x01; cycle 3 cfg_done=1, iocs=0.
- After cfg_done, push 0xA5, 0x3C with tbr=1 → two WR cycles with db_out 0xA5 then 0x3C, separated by ≥HOLD_CYC+1 cycles; tx_ready stays 1.
- Hold tbr=0, push 5 bytes with TX_DEPTH=4 → tx_ready=0 after 4th, 5th byte not accepted; raise tbr → exactly 4 writes in order, then FIFO empty.
- rda=1 and FIFO non-empty with tbr=1 in the same IDLE cycle, db_in=0x7E → RD taken first, rx_byte=0x7E with a one-cycle rx_valid, then WR.
- rda held high continuously for 3 reads → rda_stuck_cnt=3; force 300 such events → saturates at 255.
- cfg_req in IDLE with 2 bytes queued → CFG_LO/CFG_HI re-run, cfg_done low for 2 cycles, both bytes then transmitted; assert rst during WR → iocs=0 immediately, FIFO empty, CFG_LO after release.

Source files
------------

// File: rtl/spart_pkg.sv
// ---------------------------------------------------------------------------
// spart_pkg : shared states, bus addresses and defaults for the SPART sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spart_pkg;

  typedef enum logic [2:0] {
    CFG_LO = 3'd0,
    CFG_HI = 3'd1,
    IDLE   = 3'd2,
    RD     = 3'd3,
    WR     = 3'd4,
    HOLD   = 3'd5
  } state_t;

  localparam logic [1:0]  ADDR_DATA = 2'b00;
  localparam logic [1:0]  ADDR_STAT = 2'b01;
  localparam logic [1:0]  ADDR_DBL  = 2'b10;
  localparam logic [1:0]  ADDR_DBH  = 2'b11;

  localparam int          BYTE_W           = 8;
  localparam logic [15:0] BAUD_DIV_DEFAULT = 16'd325;

endpackage

`default_nettype wire

// File: rtl/spart_tx_fifo.sv
// ---------------------------------------------------------------------------
// spart_tx_fifo : synchronous byte FIFO with wrapping pointers and occupancy count
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spart_tx_fifo
  import spart_pkg::*;
#(
  parameter int TX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [BYTE_W-1:0] head
);

  localparam int PW = $clog2(TX_DEPTH);

  logic [BYTE_W-1:0] mem [TX_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PW+1)'(TX_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/spart_io_sched.sv
// ---------------------------------------------------------------------------
// spart_io_sched : SPART bus sequencer (baud setup, RX reads, queued TX writes)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spart_io_sched
  import spart_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV = BAUD_DIV_DEFAULT,
  parameter int          TX_DEPTH = 4,
  parameter int          HOLD_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_req,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  output logic [7:0] db_out,
  output logic       db_oe,
  input  logic [7:0] db_in,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       cfg_done,
  output logic [7:0] rda_stuck_cnt
);

  localparam int HW = $clog2(HOLD_CYC + 1);

  state_t        state;
  state_t        state_nxt;
  logic [HW-1:0] hold_cnt;
  logic          after_rd;
  logic          iocs_dec;
  logic          db_oe_dec;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;

  spart_tx_fifo #(.TX_DEPTH(TX_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid),
    .din   (tx_byte),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign tx_ready = !fifo_full;

  // Strobes are qualified by rst so the bus is released the moment reset falls.
  assign iocs  = iocs_dec && rst;
  assign db_oe = db_oe_dec && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= CFG_LO;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    iocs_dec  = 1'b0;
    iorw      = 1'b1;
    ioaddr    = ADDR_STAT;
    db_out    = 8'h00;
    db_oe_dec = 1'b0;
    fifo_pop  = 1'b0;
    case (state)
      CFG_LO: begin
        iocs_dec  = 1'b1;
        iorw      = 1'b0;
        ioaddr    = ADDR_DBL;
        db_out    = BAUD_DIV[7:0];
        db_oe_dec = 1'b1;
        state_nxt = CFG_HI;
      end
      CFG_HI: begin
        iocs_dec  = 1'b1;
        iorw      = 1'b0;
        ioaddr    = ADDR_DBH;
        db_out    = BAUD_DIV[15:8];
        db_oe_dec = 1'b1;
        state_nxt = IDLE;
      end
      IDLE: begin
        if (cfg_req)                             state_nxt = CFG_LO;
        else if (cfg_done && rda)                state_nxt = RD;
        else if (cfg_done && tbr && !fifo_empty) state_nxt = WR;
      end
      RD: begin
        iocs_dec  = 1'b1;
        ioaddr    = ADDR_DATA;
        state_nxt = HOLD;
      end
      WR: begin
        iocs_dec  = 1'b1;
        iorw      = 1'b0;
        ioaddr    = ADDR_DATA;
        db_out    = fifo_head;
        db_oe_dec = 1'b1;
        fifo_pop  = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (hold_cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = CFG_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_byte       <= 8'h00;
      rx_valid      <= 1'b0;
      cfg_done      <= 1'b0;
      rda_stuck_cnt <= 8'h00;
      hold_cnt      <= '0;
      after_rd      <= 1'b0;
    end else begin
      rx_valid <= (state == RD);
      if (state == RD) rx_byte <= db_in;

      if (state == CFG_HI)                cfg_done <= 1'b1;
      else if (state == IDLE && cfg_req)  cfg_done <= 1'b0;

      if (state == RD || state == WR) begin
        hold_cnt <= HW'(HOLD_CYC - 1);
        after_rd <= (state == RD);
      end else if (state == HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end

      // rda still high once status has settled after a read means the
      // receiver is producing faster than it is being drained.
      if (state == HOLD && hold_cnt == '0 && after_rd && rda &&
          rda_stuck_cnt != 8'hFF)
        rda_stuck_cnt <= rda_stuck_cnt + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spart_io_sched.sv
// ---------------------------------------------------------------------------
// tb_spart_io_sched : directed bench with a script-queue model of bus accesses
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spart_io_sched;

  localparam int          DEPTH = 4;
  localparam int          HOLDC = 2;
  localparam logic [15:0] BAUD  = 16'd325;

  localparam int K_IDLE = 0, K_CLO = 1, K_CHI = 2, K_RD = 3, K_WR = 4,
                 K_HOLD = 5, K_HLAST_RD = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_req = 1'b0, rda = 1'b0, tbr = 1'b1, tx_valid = 1'b0;
  logic [7:0] db_in = 8'h00, tx_byte = 8'h00;
  logic       iocs, iorw, db_oe, tx_ready, rx_valid, cfg_done;
  logic [1:0] ioaddr;
  logic [7:0] db_out, rx_byte, rda_stuck_cnt;

  spart_io_sched dut (
    .clk(clk), .rst(rst), .cfg_req(cfg_req), .rda(rda), .tbr(tbr),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .db_out(db_out), .db_oe(db_oe),
    .db_in(db_in), .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .cfg_done(cfg_done),
    .rda_stuck_cnt(rda_stuck_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each access is a script of bus cycles; when the script runs out
  // the bus returns to idle, and only an idle cycle arbitrates.
  int q[$];
  int script[$];
  int cur;
  int rxb_m, stuck_m;
  bit cfgd_m, rxv_m, model_ok = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      script.delete();
      cur = K_CLO;
      script.push_back(K_CHI);
      cfgd_m = 1'b0; rxv_m = 1'b0; rxb_m = 0; stuck_m = 0;
      model_ok = 1'b1;
    end else begin : upd
      int pre;
      pre   = q.size();
      rxv_m = (cur == K_RD);
      if (cur == K_RD) rxb_m = db_in;
      if (cur == K_CHI) cfgd_m = 1'b1;
      if (cur == K_HLAST_RD && rda && stuck_m < 255) stuck_m++;
      if (cur == K_WR) void'(q.pop_front());
      if (tx_valid && pre < DEPTH) q.push_back(int'(tx_byte));
      if (script.size() > 0) cur = script.pop_front();
      else if (cur != K_IDLE) cur = K_IDLE;
      else if (cfg_req) begin
        cfgd_m = 1'b0; cur = K_CLO; script.push_back(K_CHI);
      end else if (rda || (tbr && pre > 0)) begin
        cur = rda ? K_RD : K_WR;
        for (int i = 1; i < HOLDC; i++) script.push_back(K_HOLD);
        script.push_back(rda ? K_HLAST_RD : K_HOLD);
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin : cmp
      int e_cs, e_rw, e_ad, e_db, e_oe;
      e_cs = 0; e_rw = 1; e_ad = 1; e_db = 0; e_oe = 0;
      case (cur)
        K_CLO: begin e_cs = 1; e_rw = 0; e_ad = 2; e_db = int'(BAUD[7:0]);  e_oe = 1; end
        K_CHI: begin e_cs = 1; e_rw = 0; e_ad = 3; e_db = int'(BAUD[15:8]); e_oe = 1; end
        K_RD:  begin e_cs = 1; e_rw = 1; e_ad = 0; end
        K_WR:  begin e_cs = 1; e_rw = 0; e_ad = 0; e_db = q[0]; e_oe = 1; end
        default: ;
      endcase
      if (!rst) begin e_cs = 0; e_oe = 0; end
      check("iocs", int'(iocs), e_cs);
      check("iorw", int'(iorw), e_rw);
      check("ioaddr", int'(ioaddr), e_ad);
      check("db_oe", int'(db_oe), e_oe);
      if (cur != K_RD) check("db_out", int'(db_out), e_db);
      check("tx_ready", int'(tx_ready), int'(q.size() < DEPTH));
      check("rx_valid", int'(rx_valid), int'(rxv_m));
      check("rx_byte", int'(rx_byte), rxb_m);
      check("cfg_done", int'(cfg_done), int'(cfgd_m));
      check("rda_stuck_cnt", int'(rda_stuck_cnt), stuck_m);
    end
  end

  // Bus-level observation for the literal end-to-end checks.
  int wr_log[$];
  int rx_log[$];
  int cyc = 0, wr_cyc = 0, prev_wr_cyc = 0, rx_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst && iocs && !iorw && ioaddr == 2'b00) begin
      wr_log.push_back(int'(db_out));
      prev_wr_cyc = wr_cyc;
      wr_cyc = cyc;
    end
    if (rx_valid) begin
      rx_log.push_back(int'(rx_byte));
      rx_cyc = cyc;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    tx_byte = b; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  initial begin : stim
    bit found;
    // Reset and divisor programming
    repeat (3) tick();
    check("iocs_in_reset", int'(iocs), 0);
    rst = 1'b1;
    @(negedge clk);
    check("cfg_lo_addr", int'(ioaddr), 2);
    check("cfg_lo_data", int'(db_out), 8'h45);
    tick(); @(negedge clk);
    check("cfg_hi_addr", int'(ioaddr), 3);
    check("cfg_hi_data", int'(db_out), 8'h01);
    tick(); @(negedge clk);
    check("cfg_done_set", int'(cfg_done), 1);
    check("iocs_idle", int'(iocs), 0);

    // Two back-to-back bytes
    tick();
    wr_log.delete();
    push_byte(8'hA5);
    push_byte(8'h3C);
    check("tx_ready_two", int'(tx_ready), 1);
    repeat (15) tick();
    check("two_wr_count", wr_log.size(), 2);
    check("two_wr_0", wr_log[0], 8'hA5);
    check("two_wr_1", wr_log[1], 8'h3C);
    check("two_wr_gap_ok", int'((wr_cyc - prev_wr_cyc) >= HOLDC + 1), 1);

    // Fill past capacity with tbr low
    tbr = 1'b0;
    wr_log.delete();
    for (int i = 0; i < 5; i++) begin
      tx_byte = 8'(8'h11 * (i + 1)); tx_valid = 1'b1;
      tick();
      if (i == 3) check("tx_ready_full", int'(tx_ready), 0);
    end
    tx_valid = 1'b0;
    tbr = 1'b1;
    repeat (20) tick();
    check("full_wr_count", wr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check("full_wr_order", wr_log[i], 8'h11 * (i + 1));
    check("tx_ready_drained", int'(tx_ready), 1);

    // Read takes priority over a pending write
    tbr = 1'b0;
    wr_log.delete(); rx_log.delete();
    push_byte(8'h99);
    db_in = 8'h7E; rda = 1'b1; tbr = 1'b1;
    tick();
    rda = 1'b0;
    repeat (12) tick();
    check("prio_rx_count", rx_log.size(), 1);
    check("prio_rx_byte", rx_log[0], 8'h7E);
    check("prio_wr_count", wr_log.size(), 1);
    check("prio_wr_byte", wr_log[0], 8'h99);
    check("prio_rd_first", int'(rx_cyc < wr_cyc), 1);
    repeat (8) tick();

    // rda held high across reads
    rda = 1'b1;
    repeat (12) tick();
    rda = 1'b0;
    check("stuck_three", int'(rda_stuck_cnt), 3);
    repeat (8) tick();
    rda = 1'b1;
    repeat (1200) tick();
    rda = 1'b0;
    check("stuck_saturate", int'(rda_stuck_cnt), 255);
    repeat (8) tick();

    // Re-configuration with bytes queued
    tbr = 1'b0;
    wr_log.delete();
    push_byte(8'h5A);
    push_byte(8'h6B);
    tick();
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    @(negedge clk);
    check("recfg_lo_addr", int'(ioaddr), 2);
    check("recfg_done_lo", int'(cfg_done), 0);
    tick(); @(negedge clk);
    check("recfg_hi_addr", int'(ioaddr), 3);
    check("recfg_done_hi", int'(cfg_done), 0);
    tick(); @(negedge clk);
    check("recfg_done_set", int'(cfg_done), 1);
    tbr = 1'b1;
    repeat (12) tick();
    check("recfg_wr_count", wr_log.size(), 2);
    check("recfg_wr_0", wr_log[0], 8'h5A);
    check("recfg_wr_1", wr_log[1], 8'h6B);

    // Reset in the middle of a write
    tbr = 1'b0;
    push_byte(8'hC3);
    push_byte(8'hD4);
    tbr = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (iocs && !iorw && ioaddr == 2'b00) found = 1'b1;
    end
    check("reached_wr", int'(found), 1);
    #1 rst = 1'b0;
    #1 check("iocs_async_drop", int'(iocs), 0);
    check("db_oe_async_drop", int'(db_oe), 0);
    tick();
    wr_log.delete();
    rst = 1'b1;
    @(negedge clk);
    check("rst_cfg_lo_addr", int'(ioaddr), 2);
    check("rst_fifo_empty", int'(tx_ready), 1);
    repeat (12) tick();
    check("rst_no_writes", wr_log.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
